// File: rtl/debug_ctrl_pkg.sv
// debug_ctrl_pkg: opcode, status and FSM state encodings shared by the
// debug command sequencer and its dump streamer.
`default_nettype none

package debug_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_RUN   = 4'd1;
  localparam logic [3:0] OP_STEPI = 4'd2;
  localparam logic [3:0] OP_DUMP  = 4'd3;
  localparam logic [3:0] OP_HALT  = 4'd4;

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_BREAK   = 3'd1,
    ST_TIMEOUT = 3'd2,
    ST_ABORT   = 3'd3,
    ST_BADCMD  = 3'd4
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_STEP     = 3'd2,
    S_DUMP_RD  = 3'd3,
    S_DUMP_OUT = 3'd4,
    S_DONE     = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dbg_dump_streamer.sv
// dbg_dump_streamer: walks register file then PC, presenting each word on a
// valid/ready channel with a hold register so stalled words stay stable.
`default_nettype none

module dbg_dump_streamer #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int AW       = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              rd_phase_i,
  input  logic              out_phase_i,
  output logic [AW-1:0]     reg_rd_addr_o,
  input  logic [DATA_W-1:0] reg_rd_data_i,
  input  logic [DATA_W-1:0] cpu_pc_i,
  output logic              dump_valid_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  input  logic              dump_ready_i,
  output logic              word_done_o,
  output logic              done_o
);

  localparam int IW = $clog2(NUM_REGS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS);

  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] hold_q;
  logic              loaded_q;
  logic              last;
  logic              hs;
  logic [DATA_W-1:0] src;

  assign last = (idx_q == LAST_IDX);
  assign src  = last ? cpu_pc_i : reg_rd_data_i;
  assign hs   = out_phase_i && dump_ready_i;

  assign reg_rd_addr_o = (rd_phase_i && !last) ? idx_q[AW-1:0] : '0;
  assign dump_valid_o  = out_phase_i;
  assign dump_last_o   = out_phase_i && last;
  // First output cycle passes read data straight through; later stall cycles replay the held copy.
  assign dump_data_o   = (out_phase_i && !loaded_q) ? src : hold_q;
  assign word_done_o   = hs;
  assign done_o        = hs && last;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q    <= '0;
      hold_q   <= '0;
      loaded_q <= 1'b0;
    end else if (start_i) begin
      idx_q    <= '0;
      loaded_q <= 1'b0;
    end else if (out_phase_i) begin
      if (!loaded_q) hold_q <= src;
      loaded_q <= !dump_ready_i;
      if (hs) idx_q <= idx_q + IW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/debug_cmd_sequencer.sv
// debug_cmd_sequencer: accepts one host debug command at a time, drives the
// core halt line, counts retirements/cycles and streams register dumps.
`default_nettype none

module debug_cmd_sequencer
  import debug_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ARG_W    = 16,
  localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [3:0]        cmd_op_i,
  input  logic [ARG_W-1:0]  cmd_arg_i,
  input  logic              cmd_abort_i,
  output logic              cpu_halt_o,
  input  logic              instr_retired_i,
  input  logic              breakpoint_fired_i,
  input  logic [DATA_W-1:0] cpu_pc_i,
  output logic [AW-1:0]     reg_rd_addr_o,
  input  logic [DATA_W-1:0] reg_rd_data_i,
  output logic              dump_valid_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  input  logic              dump_ready_i,
  output logic              command_complete_o,
  output logic [2:0]        cmd_status_o
);

  state_e             state_q, state_d;
  status_e            status_q, status_d;
  logic [ARG_W-1:0]   cnt_q, cnt_d;
  logic               bounded_q, bounded_d;
  logic               halt_q;
  logic               dump_start;
  logic               dump_word;
  logic               dump_done;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      status_q  <= ST_OK;
      cnt_q     <= '0;
      bounded_q <= 1'b0;
      halt_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      cnt_q     <= cnt_d;
      bounded_q <= bounded_d;
      halt_q    <= !((state_d == S_RUN) || (state_d == S_STEP));
    end
  end

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    cnt_d      = cnt_q;
    bounded_d  = bounded_q;
    dump_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          case (cmd_op_i)
            OP_NOP, OP_HALT: begin
              state_d  = S_DONE;
              status_d = ST_OK;
            end
            OP_RUN: begin
              state_d   = S_RUN;
              cnt_d     = cmd_arg_i;
              bounded_d = (cmd_arg_i != '0);
            end
            OP_STEPI: begin
              state_d = S_STEP;
              cnt_d   = (cmd_arg_i == '0) ? ARG_W'(1) : cmd_arg_i;
            end
            OP_DUMP: begin
              state_d    = S_DUMP_RD;
              dump_start = 1'b1;
            end
            default: begin
              state_d  = S_DONE;
              status_d = ST_BADCMD;
            end
          endcase
        end
      end
      S_RUN: begin
        if (bounded_q) cnt_d = cnt_q - ARG_W'(1);
        if (cmd_abort_i) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (breakpoint_fired_i) begin
          state_d  = S_DONE;
          status_d = ST_BREAK;
        end else if (bounded_q && (cnt_q == ARG_W'(1))) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end
      end
      S_STEP: begin
        if (cmd_abort_i) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (breakpoint_fired_i) begin
          state_d  = S_DONE;
          status_d = ST_BREAK;
        end else if (instr_retired_i && !halt_q) begin
          cnt_d = cnt_q - ARG_W'(1);
          if (cnt_q == ARG_W'(1)) begin
            state_d  = S_DONE;
            status_d = ST_OK;
          end
        end
      end
      S_DUMP_RD: state_d = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (dump_done) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end else if (dump_word) begin
          state_d = S_DUMP_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready_o        = (state_q == S_IDLE) && !reset_i;
  assign command_complete_o = (state_q == S_DONE);
  assign cmd_status_o       = status_q;
  assign cpu_halt_o         = halt_q;

  dbg_dump_streamer #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .AW       (AW)
  ) u_streamer (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .start_i       (dump_start),
    .rd_phase_i    (state_q == S_DUMP_RD),
    .out_phase_i   (state_q == S_DUMP_OUT),
    .reg_rd_addr_o (reg_rd_addr_o),
    .reg_rd_data_i (reg_rd_data_i),
    .cpu_pc_i      (cpu_pc_i),
    .dump_valid_o  (dump_valid_o),
    .dump_data_o   (dump_data_o),
    .dump_last_o   (dump_last_o),
    .dump_ready_i  (dump_ready_i),
    .word_done_o   (dump_word),
    .done_o        (dump_done)
  );

endmodule

`default_nettype wire

// File: doc/debug_cmd_sequencer.md
Name: debug_cmd_sequencer

Overview:
- Command sequencer between the host debug link and the RISC-V CPU core.
- Accepts one debug command at a time and drives the core's halt line. Supported commands: RUN, STEPI N, register DUMP, HALT.
- Counts retired instructions and watches for breakpoints.
- Streams a register-file-plus-PC snapshot back over a valid/ready channel.
- Replaces ad-hoc halt/command_complete logic in the debug harness.

Parameters:
- NUM_REGS, 32, register-file entries dumped (dump length is NUM_REGS+1 words).
- DATA_W, 32, register and PC width.
- ARG_W, 16, command argument width (step count or run timeout).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  host command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  4  opcode: 0 NOP, 1 RUN, 2 STEPI, 3 DUMP, 4 HALT; others are illegal.
- cmd_arg  input  ARG_W  STEPI: instruction count; RUN: cycle timeout, 0 = unbounded.
- cmd_abort  input  1  forces an active RUN/STEPI to stop.
- cpu_halt  output  1  registered halt to the CPU core.
- instr_retired  input  1  one-cycle pulse per retired instruction.
- breakpoint_fired  input  1  EBREAK/breakpoint indication from the core.
- cpu_pc  input  DATA_W  current PC of the core.
- reg_rd_addr  output  $clog2(NUM_REGS)  register-file debug read address.
- reg_rd_data  input  DATA_W  read data, valid one cycle after the address.
- dump_valid  output  1  dump word present.
- dump_data  output  DATA_W  dump word.
- dump_last  output  1  marks the final (PC) word.
- dump_ready  input  1  host accepts the dump word.
- command_complete  output  1  one-cycle pulse when a command finishes.
- cmd_status  output  3  result: 0 OK, 1 BREAK, 2 TIMEOUT, 3 ABORT, 4 BADCMD. Held until the next accept.

Behaviour:
- Reset values: state IDLE, cpu_halt=1, cmd_ready=0 while in reset, dump_valid=0, dump_last=0, dump_data=0, reg_rd_addr=0, command_complete=0, cmd_status=0, counters 0.
- Reset mid-operation aborts everything immediately. No dump word or complete pulse is emitted after reset.
- States: IDLE, RUN, STEP, DUMP_RD, DUMP_OUT, DONE.
- IDLE: cmd_ready=1 (combinational from state). Accept occurs on cmd_valid&&cmd_ready. Next state by op:
  - NOP/HALT -> DONE, status OK.
  - RUN -> RUN.
  - STEPI -> STEP.
  - DUMP -> DUMP_RD.
  - illegal op -> DONE, status BADCMD.
- cpu_halt is registered:
  - It goes 0 on the clock edge that enters RUN/STEP, i.e. the cycle after accept.
  - It goes 1 on the edge that leaves RUN/STEP.
  - It is 1 in every other state.
- RUN:
  - Cycle counter is loaded with cmd_arg at accept. It decrements each cycle in RUN when cmd_arg != 0.
  - Exit priority when several occur in the same cycle: abort > breakpoint > timeout.
  - breakpoint_fired -> DONE, BREAK. Counter reaching 0 (bounded run) -> DONE, TIMEOUT. cmd_abort -> DONE, ABORT.
- STEP:
  - Step counter is loaded with max(cmd_arg,1); cmd_arg=0 behaves as 1.
  - It decrements on instr_retired while cpu_halt=0.
  - A retire that brings the counter to 0 -> DONE, OK. cpu_halt is 1 the next cycle; retirements during the halt-propagation cycle are not counted.
  - Same priority as RUN: abort > breakpoint > final retire. A breakpoint coincident with the final retire yields BREAK.
- DUMP:
  - Index i runs 0..NUM_REGS.
  - DUMP_RD: for i<NUM_REGS, drive reg_rd_addr=i.
  - Next cycle enter DUMP_OUT: capture reg_rd_data (or cpu_pc when i==NUM_REGS) into dump_data and assert dump_valid.
  - dump_data and dump_last stay stable while dump_valid&&!dump_ready.
  - On handshake: i increments and the FSM returns to DUMP_RD. After the last word (dump_last=1) it goes to DONE, OK.
  - Minimum rate is one word per 2 cycles. cmd_abort is ignored during DUMP.
- DONE: command_complete=1 for exactly one cycle, cmd_status updated in the same cycle, then return to IDLE.
- cmd_valid while not in IDLE is not accepted (cmd_ready=0), and cmd_op is not sampled.
- Counter widths are ARG_W. Counters never wrap, because exit occurs at 0.

Decomposition:
- Package debug_ctrl_pkg holds:
  - opcode localparams/enum (OP_NOP..OP_HALT);
  - status enum (ST_OK..ST_BADCMD);
  - FSM state enum.
- One sub-module, dbg_dump_streamer: register/PC walk with a valid/ready output skid. The sequencer starts it and receives a done flag.

Test Plan:
- STEPI arg=3, instr_retired pulses every 2 cycles -> cpu_halt low for ~6 cycles, high the cycle after the 3rd retire; complete pulse; status 0.
- RUN arg=0, breakpoint_fired after 10 cycles -> cpu_halt high next cycle; status 1; a 2nd retire in the halt cycle is not counted.
- RUN arg=5, no breakpoint -> exactly 5 cycles with cpu_halt=0; status 2. Also: STEPI arg=0 retires exactly 1 instruction.
- DUMP with reg[i]=i*4 and cpu_pc=0x100, dump_ready toggled randomly -> 33 words 0,4,..,124,0x100 in order; dump_last only on 0x100; dump_data stable while stalled.
- cmd_op=7 -> complete pulse 1 cycle later, status 4, cpu_halt remains 1. Also: cmd_abort during STEPI arg=100 -> status 3.
- reset asserted mid-DUMP and mid-RUN -> outputs return to reset values asynchronously; after release, a fresh STEPI arg=1 completes with status 0.
